// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file for the 3-stage RV32I pipeline.
// Services decoder CSR strobes (RW/RS/RC and immediate forms), synchronizes the
// timer/external interrupt levels into mip, takes interrupt traps and mret,
// and requests a PC redirect in the same cycle.
//
// Optional build macro: CSR_MCYCLE_EN adds a 64-bit mcycle counter at
// 0xB00 (low) / 0xB80 (high).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   csr_reg_wr/rd     CSR write/read strobes from the decoder
//   funct3            CSR operation (RW/RS/RC, bit 2 selects zimm source)
//   csr_addr          12-bit CSR address
//   rs1_data, zimm    register / immediate source operands
//   pc                PC of the instruction in this stage
//   is_mret           mret in this stage
//   timer_irq/ext_irq asynchronous level interrupts
//   csr_rdata         old value of the addressed CSR (combinational)
//   epc_taken         PC redirect request (combinational)
//   excp_pc           redirect target (combinational)
module csr_file #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_reg_wr,
    input  logic        csr_reg_rd,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic [31:0] pc,
    input  logic        is_mret,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        epc_taken,
    output logic [31:0] excp_pc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
`endif

    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0880;
    localparam logic [31:0] MTVEC_MASK   = 32'hFFFF_FFFD;
    localparam logic [31:0] MEPC_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] MCAUSE_MASK  = 32'h8000_000F;

    logic [31:0] mstatus_q;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [1:0]  tmr_sync_q;
    logic [1:0]  ext_sync_q;
`ifdef CSR_MCYCLE_EN
    logic [63:0] mcycle_q;
`endif

    logic [31:0] mip_val;
    logic [31:0] old_val;
    logic [31:0] src_val;
    logic [31:0] new_val;
    logic [31:0] pend;
    logic [31:0] trap_base;
    logic [31:0] trap_vec;
    logic [3:0]  cause;
    logic        trap;

    // mip is a live view of the synchronized interrupt levels
    always_comb begin
        mip_val     = '0;
        mip_val[7]  = tmr_sync_q[1];
        mip_val[11] = ext_sync_q[1];
    end

    // Current value of the addressed CSR
    always_comb begin
        old_val = '0;
        case (csr_addr)
            ADDR_MSTATUS: old_val = mstatus_q;
            ADDR_MIE:     old_val = mie_q;
            ADDR_MTVEC:   old_val = mtvec_q;
            ADDR_MEPC:    old_val = mepc_q;
            ADDR_MCAUSE:  old_val = mcause_q;
            ADDR_MIP:     old_val = mip_val;
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:  old_val = mcycle_q[31:0];
            ADDR_MCYCLEH: old_val = mcycle_q[63:32];
`endif
            default:      old_val = '0;
        endcase
    end

    // Read-modify-write value; unused funct3 encodings leave the CSR unchanged
    always_comb begin
        src_val = funct3[2] ? {27'b0, zimm} : rs1_data;
        case (funct3[1:0])
            2'b01:   new_val = src_val;
            2'b10:   new_val = old_val | src_val;
            2'b11:   new_val = old_val & ~src_val;
            default: new_val = old_val;
        endcase
    end

    // Interrupt arbitration: external beats timer; vectored mode adds 4*cause
    always_comb begin
        pend      = mie_q & mip_val;
        trap      = rst_n & mstatus_q[3] & (|pend);
        cause     = pend[11] ? 4'd11 : 4'd7;
        trap_base = {mtvec_q[31:2], 2'b00};
        trap_vec  = mtvec_q[0] ? (trap_base + {26'b0, cause, 2'b00}) : trap_base;
    end

    // Outputs are forced low while reset is asserted
    always_comb begin
        csr_rdata = '0;
        epc_taken = 1'b0;
        excp_pc   = '0;
        if (rst_n) begin
            if (csr_reg_rd) begin
                csr_rdata = old_val;
            end
            if (trap) begin
                epc_taken = 1'b1;
                excp_pc   = trap_vec;
            end else if (is_mret) begin
                epc_taken = 1'b1;
                excp_pc   = mepc_q;
            end
        end
    end

    // Two-flop interrupt synchronizers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_sync_q <= '0;
            ext_sync_q <= '0;
        end else begin
            tmr_sync_q <= {tmr_sync_q[0], timer_irq};
            ext_sync_q <= {ext_sync_q[0], ext_irq};
        end
    end

    // CSR state: a trap flushes the instruction, so its write/mret is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q <= '0;
            mie_q     <= '0;
            mtvec_q   <= MTVEC_RST & MTVEC_MASK;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else if (trap) begin
            mepc_q    <= pc & MEPC_MASK;
            mcause_q  <= {1'b1, 27'b0, cause};
            mstatus_q <= {24'b0, mstatus_q[3], 3'b0, 1'b0, 3'b0};
        end else begin
            if (csr_reg_wr) begin
                case (csr_addr)
                    ADDR_MSTATUS: mstatus_q <= new_val & MSTATUS_MASK;
                    ADDR_MIE:     mie_q     <= new_val & MIE_MASK;
                    ADDR_MTVEC:   mtvec_q   <= new_val & MTVEC_MASK;
                    ADDR_MEPC:    mepc_q    <= new_val & MEPC_MASK;
                    ADDR_MCAUSE:  mcause_q  <= new_val & MCAUSE_MASK;
                    default:      ;
                endcase
            end
            // Later assignment lets mret override a simultaneous mstatus write
            if (is_mret) begin
                mstatus_q <= {24'b0, 1'b1, 3'b0, mstatus_q[7], 3'b0};
            end
        end
    end

`ifdef CSR_MCYCLE_EN
    // Free-running cycle counter; a written half holds for that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q <= '0;
        end else if (csr_reg_wr && !trap && csr_addr == ADDR_MCYCLE) begin
            mcycle_q[31:0] <= new_val;
        end else if (csr_reg_wr && !trap && csr_addr == ADDR_MCYCLEH) begin
            mcycle_q[63:32] <= new_val;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios followed by random
// CSR traffic, each cycle compared against a behavioural CSR model.
module tb_csr_file;

    logic        clk;
    logic        rst_n;
    logic        csr_reg_wr;
    logic        csr_reg_rd;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic [31:0] pc;
    logic        is_mret;
    logic        timer_irq;
    logic        ext_irq;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] excp_pc;

    int n_chk;
    int n_fail;

    // Behavioural model state
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
    logic [1:0]  m_tmr, m_ext;   // interrupt level history, [1] is what mip shows
`ifdef CSR_MCYCLE_EN
    logic [63:0] m_mcycle;
`endif

    logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                12'h344, 12'hB00, 12'hB80, 12'h340, 12'hFFF};
    logic [2:0]  ops   [6]  = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    csr_file #(.MTVEC_RST(32'h0000_0203)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .csr_reg_wr(csr_reg_wr),
        .csr_reg_rd(csr_reg_rd),
        .funct3    (funct3),
        .csr_addr  (csr_addr),
        .rs1_data  (rs1_data),
        .zimm      (zimm),
        .pc        (pc),
        .is_mret   (is_mret),
        .timer_irq (timer_irq),
        .ext_irq   (ext_irq),
        .csr_rdata (csr_rdata),
        .epc_taken (epc_taken),
        .excp_pc   (excp_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_mip();
        return (m_ext[1] ? 32'h800 : 32'h0) | (m_tmr[1] ? 32'h80 : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip();
`ifdef CSR_MCYCLE_EN
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mcause = 0;
        m_mtvec   = 32'h0000_0201;
        m_tmr = 0; m_ext = 0;
`ifdef CSR_MCYCLE_EN
        m_mcycle = 0;
`endif
    endtask

    task automatic idle();
        csr_reg_wr = 0; csr_reg_rd = 0; funct3 = 3'b001; csr_addr = 0;
        rs1_data = 0; zimm = 0; is_mret = 0;
    endtask

    task automatic set_csr(input logic wr, input logic rd, input logic [2:0] f3,
                           input logic [11:0] a, input logic [31:0] d, input logic [4:0] z);
        csr_reg_wr = wr; csr_reg_rd = rd; funct3 = f3; csr_addr = a;
        rs1_data = d; zimm = z;
    endtask

    // One clock cycle: check combinational outputs against the model, then
    // advance the model across the rising edge.
    task automatic cyc(input string tag);
        logic [31:0] pend, e_rd, e_pc, base, old, src, nv, old_ms;
        logic        trap;
        int          cause;
        #1;
        pend  = m_mie & m_mip();
        trap  = m_mstatus[3] && (pend != 0);
        cause = pend[11] ? 11 : 7;
        base  = m_mtvec & 32'hFFFF_FFFC;
        e_rd  = csr_reg_rd ? m_read(csr_addr) : 32'h0;
        if (trap)         e_pc = m_mtvec[0] ? base + 32'(cause * 4) : base;
        else if (is_mret) e_pc = m_mepc;
        else              e_pc = 0;
        chk({tag, ".rdata"}, csr_rdata, e_rd);
        chk({tag, ".taken"}, 32'(epc_taken), 32'(trap || is_mret));
        chk({tag, ".pc"}, excp_pc, e_pc);
        old = m_read(csr_addr);
        src = funct3[2] ? {27'b0, zimm} : rs1_data;
        case (funct3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            2'b11:   nv = old & ~src;
            default: nv = old;
        endcase
        old_ms = m_mstatus;
        @(posedge clk);
        if (trap) begin
            m_mepc    = pc & 32'hFFFF_FFFC;
            m_mcause  = 32'h8000_0000 | 32'(cause);
            m_mstatus = old_ms[3] ? 32'h80 : 32'h0;
        end else begin
            if (csr_reg_wr) begin
                case (csr_addr)
                    12'h300: m_mstatus = nv & 32'h88;
                    12'h304: m_mie     = nv & 32'h880;
                    12'h305: m_mtvec   = nv & 32'hFFFF_FFFD;
                    12'h341: m_mepc    = nv & 32'hFFFF_FFFC;
                    12'h342: m_mcause  = nv & 32'h8000_000F;
                    default: ;
                endcase
            end
            if (is_mret) m_mstatus = 32'h80 | (old_ms[7] ? 32'h8 : 32'h0);
        end
`ifdef CSR_MCYCLE_EN
        if (!trap && csr_reg_wr && csr_addr == 12'hB00)      m_mcycle[31:0]  = nv;
        else if (!trap && csr_reg_wr && csr_addr == 12'hB80) m_mcycle[63:32] = nv;
        else                                                  m_mcycle = m_mcycle + 64'd1;
`endif
        m_tmr = {m_tmr[0], timer_irq};
        m_ext = {m_ext[0], ext_irq};
        #1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        m_reset();
        rst_n = 0; pc = 0; timer_irq = 0; ext_irq = 0;
        idle();
        csr_reg_rd = 1; csr_addr = 12'h305; is_mret = 1;
        #3;
        chk("rst.rdata", csr_rdata, 32'h0);
        chk("rst.taken", 32'(epc_taken), 32'h0);
        chk("rst.pc", excp_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        m_reset(); idle(); rst_n = 1;

        // mtvec reset value (bit 1 forced low) and RW masking
        set_csr(0, 1, 3'b001, 12'h305, 0, 0);
        #1 chk("mtvec_rst", csr_rdata, 32'h0000_0201);
        cyc("rd_mtvec_rst");
        set_csr(1, 1, 3'b001, 12'h305, 32'h8000_0103, 0);
        #1 chk("mtvec_rw_old", csr_rdata, 32'h0000_0201);
        cyc("mtvec_rw");
        set_csr(0, 1, 3'b001, 12'h305, 0, 0);
        #1 chk("mtvec_rd", csr_rdata, 32'h8000_0101);
        cyc("mtvec_rd");

        // mie set/clear sequence
        set_csr(1, 1, 3'b110, 12'h304, 0, 5'd0);
        #1 chk("mie_rsi", csr_rdata, 32'h0);
        cyc("mie_rsi");
        set_csr(1, 1, 3'b010, 12'h304, 32'h0000_0880, 0);
        #1 chk("mie_rs", csr_rdata, 32'h0);
        cyc("mie_rs");
        set_csr(1, 1, 3'b011, 12'h304, 32'h0000_0080, 0);
        #1 chk("mie_rc", csr_rdata, 32'h880);
        cyc("mie_rc");
        set_csr(0, 1, 3'b001, 12'h304, 0, 0);
        #1 chk("mie_rd", csr_rdata, 32'h800);
        cyc("mie_rd");

        // Timer trap with vectored mtvec
        set_csr(1, 0, 3'b001, 12'h300, 32'h8, 0);    cyc("set_mstatus");
        set_csr(1, 0, 3'b001, 12'h304, 32'h80, 0);   cyc("set_mie");
        set_csr(1, 0, 3'b001, 12'h305, 32'h101, 0);  cyc("set_mtvec");
        idle(); pc = 32'h40; timer_irq = 1;
        cyc("tirq_a");
        timer_irq = 0;
        cyc("tirq_b");
        #1;
        chk("ttrap.taken", 32'(epc_taken), 32'h1);
        chk("ttrap.pc", excp_pc, 32'h11C);
        cyc("ttrap");
        set_csr(0, 1, 3'b001, 12'h341, 0, 0);
        #1 chk("mepc", csr_rdata, 32'h40);
        cyc("rd_mepc");
        set_csr(0, 1, 3'b001, 12'h342, 0, 0);
        #1 chk("mcause_t", csr_rdata, 32'h8000_0007);
        cyc("rd_mcause");
        set_csr(0, 1, 3'b001, 12'h300, 0, 0);
        #1 chk("mstatus_t", csr_rdata, 32'h80);
        cyc("rd_mstatus");

        // Both IRQs: external wins, mret re-enables, trap re-entered; the
        // flushed instruction's mepc write is dropped
        set_csr(1, 0, 3'b001, 12'h304, 32'h880, 0);  cyc("set_mie2");
        set_csr(1, 0, 3'b001, 12'h300, 32'h8, 0);
        timer_irq = 1; ext_irq = 1;
        cyc("both_a");
        idle(); pc = 32'h88;
        cyc("both_b");
        #1 chk("etrap.taken", 32'(epc_taken), 32'h1);
        cyc("etrap");
        set_csr(0, 1, 3'b001, 12'h342, 0, 0);
        #1 chk("mcause_e", csr_rdata, 32'h8000_000B);
        cyc("rd_mcause2");
        idle(); is_mret = 1; pc = 32'h200;
        #1 chk("mret.pc", excp_pc, 32'h88);
        cyc("mret");
        idle(); pc = 32'h90;
        set_csr(1, 1, 3'b001, 12'h341, 32'h1234_5678, 0);
        #1;
        chk("retrap.taken", 32'(epc_taken), 32'h1);
        chk("retrap.old", csr_rdata, 32'h88);
        cyc("retrap");
        set_csr(0, 1, 3'b001, 12'h341, 0, 0);
        #1 chk("mepc_drop", csr_rdata, 32'h90);
        cyc("rd_mepc2");
        timer_irq = 0; ext_irq = 0;
        set_csr(1, 0, 3'b001, 12'h304, 0, 0);        cyc("clr_mie");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            csr_reg_wr = 1'($urandom_range(0, 1));
            csr_reg_rd = ($urandom_range(0, 3) != 0);
            funct3     = ops[$urandom_range(0, 5)];
            csr_addr   = addrs[$urandom_range(0, 9)];
            rs1_data   = $urandom;
            zimm       = 5'($urandom);
            pc         = $urandom;
            is_mret    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
            if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
            cyc("rand");
        end

        // Reset asserted while a trap redirect is active
        idle(); timer_irq = 0; ext_irq = 0;
        cyc("quiet_a"); cyc("quiet_b");
        set_csr(1, 0, 3'b001, 12'h300, 32'h8, 0);    cyc("set_mstatus3");
        set_csr(1, 0, 3'b001, 12'h304, 32'h800, 0);  cyc("set_mie3");
        idle(); ext_irq = 1;
        cyc("eirq_a"); cyc("eirq_b");
        csr_reg_rd = 1; csr_addr = 12'h305; is_mret = 1;
        #1 chk("pre_rst.taken", 32'(epc_taken), 32'h1);
        #1 rst_n = 0;
        #1;
        chk("mid_rst.taken", 32'(epc_taken), 32'h0);
        chk("mid_rst.pc", excp_pc, 32'h0);
        chk("mid_rst.rdata", csr_rdata, 32'h0);
        @(posedge clk);
        #1;
        m_reset(); idle(); ext_irq = 0; rst_n = 1;

        repeat (5) cyc("post_rst");
        set_csr(0, 1, 3'b001, 12'hB00, 0, 0);
`ifdef CSR_MCYCLE_EN
        #1 chk("mcycle5", csr_rdata, 32'd5);
`else
        #1 chk("mcycle_absent", csr_rdata, 32'd0);
`endif
        cyc("rd_mcycle");
        set_csr(0, 1, 3'b001, 12'h300, 0, 0);
        #1 chk("mstatus_rst", csr_rdata, 32'h0);
        cyc("rd_mstatus_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file that services the CSR read/write strobes produced by the instruction decoder, and arbitrates timer and external interrupts for the 3-stage RV32I pipeline. It sits in the execute/write-back stage. It returns old CSR values on the `wb_sel = 2'b11` write-back path, and redirects the PC on trap entry or `mret`.

## Interface
Parameters:
- `MTVEC_RST`, default 32'h0000_0000: reset value of `mtvec`.

Ports:
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `csr_reg_wr` input, 1: CSR write strobe from the decoder.
- `csr_reg_rd` input, 1: CSR read strobe from the decoder.
- `funct3` input, 3: CSR operation. 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- `csr_addr` input, 12: CSR address (instruction bits 31:20).
- `rs1_data` input, 32: register source operand.
- `zimm` input, 5: immediate source operand (instruction bits 19:15), zero-extended.
- `pc` input, 32: PC of the instruction in this stage.
- `is_mret` input, 1: an `mret` instruction is in this stage.
- `timer_irq` input, 1: level-sensitive timer interrupt, asynchronous to the pipeline.
- `ext_irq` input, 1: level-sensitive external interrupt, asynchronous to the pipeline.
- `csr_rdata` output, 32: old value of the addressed CSR.
- `epc_taken` output, 1: PC redirect request.
- `excp_pc` output, 32: redirect target.

## Operation
Implemented CSRs. Any other address reads 0 and ignores writes.
- `mstatus` (0x300): only MIE (bit 3) and MPIE (bit 7) are writable; all other bits read 0.
- `mie` (0x304): only MTIE (bit 7) and MEIE (bit 11) are writable.
- `mip` (0x344): read-only. MTIP (bit 7) and MEIP (bit 11) hold the synchronized IRQ levels.
- `mtvec` (0x305): bits 31:2 hold BASE. Bit 0 is MODE. Bit 1 is hardwired 0.
- `mepc` (0x341): bits 1:0 are hardwired 0.
- `mcause` (0x342): bit 31 is the interrupt flag, bits 3:0 the cause code, all other bits 0.

CSR read and write:
- `csr_rdata` is the current (old) value of `csr_addr` when `csr_reg_rd` = 1, and 0 otherwise.
- Source operand `src` is `rs1_data` when funct3[2] = 0, and `{27'b0, zimm}` when funct3[2] = 1.
- New value: RW writes `src`; RS writes `old | src`; RC writes `old & ~src`.
- The write is applied on the rising edge when `csr_reg_wr` = 1, subject to the masks above.

Interrupt synchronization:
- `timer_irq` and `ext_irq` each pass through a 2-flop synchronizer into `mip`.

Trap entry:
- Condition: `irq_pend = mstatus.MIE & |(mie & mip)`.
- Priority: external (cause 11) over timer (cause 7).
- `epc_taken` = 1 in the same cycle as the condition.
- Target: `excp_pc` = BASE when MODE = 0, and BASE + 4·cause when MODE = 1.
- On the edge: `mepc` ← `pc`, `mcause` ← {1, cause}, MPIE ← MIE, MIE ← 0.

mret:
- When `is_mret` = 1 and no trap is entered: `epc_taken` = 1 and `excp_pc` = `mepc`.
- On the edge: MIE ← MPIE, MPIE ← 1.

When neither a trap nor an mret occurs: `epc_taken` = 0 and `excp_pc` = 0.

## Timing
- Reset (asynchronous, `rst_n` low): all CSRs and synchronizer flops go to 0, except `mtvec` ← `MTVEC_RST` with bit 1 forced to 0.
- Outputs during reset: `csr_rdata` = 0, `epc_taken` = 0, `excp_pc` = 0.
- Reads: combinational, zero latency.
- Writes: visible to a read in the next cycle.
- IRQ latency: an IRQ rising at edge N is visible in `mip` after edge N+2. `epc_taken` can assert in that same cycle (N+2).
- Trap vs. CSR write or mret in the same cycle: the trap wins. The CSR write and the mret are suppressed entirely, because that instruction is flushed and re-executed from `mepc`.
- mret vs. CSR write to `mstatus` in the same cycle: cannot occur (they are distinct instructions). If both strobes are asserted anyway, the mret update wins.
- Trap blocking: MIE is cleared on trap entry, so no second trap is taken until `mret` or a software write sets MIE.
- Reset mid-trap: `rst_n` asserted while `epc_taken` = 1 drops `epc_taken` immediately, and no CSR update occurs.

## Configuration
- `CSR_MCYCLE_EN` defined: adds a 64-bit free-running `mcycle` counter.
  - Readable at 0xB00 (low word) and 0xB80 (high word); writable through the RW/RS/RC semantics above.
  - Increments by 1 every cycle and wraps at 2^64−1.
  - A write to either half replaces that half on the edge, and the counter does not increment in that cycle.
  - Reset value is 0.
- `CSR_MCYCLE_EN` undefined: 0xB00 and 0xB80 behave as unimplemented (read 0, writes ignored), and no counter logic exists.

## Test plan
- CSRRW `mtvec` with `rs1_data` = 32'h8000_0103, then read → `csr_rdata` = 32'h8000_0101. In the write cycle, `csr_rdata` = `MTVEC_RST`.
- CSRRSI `mie` with zimm = 0, then CSRRS `mie` with `rs1_data` = 32'h0000_0880, then CSRRC with 32'h0000_0080 → reads return 0, 0, 32'h880, then 32'h800 on the following read.
- `mstatus` = 8, `mie` = 32'h80, `mtvec` = 32'h100 with MODE = 1, pulse `timer_irq` at edge N with `pc` = 32'h40:
  - → `epc_taken` = 1 in cycle N+2, `excp_pc` = 32'h11C.
  - → then `mepc` = 32'h40, `mcause` = 32'h8000_0007, `mstatus` = 32'h80.
- Both IRQs held with both enables set → `mcause` = 32'h8000_000B. `mret` then gives `excp_pc` = `mepc` and `mstatus` = 32'h88. Since the IRQs are still held, a trap is re-entered in the next cycle.
- A trap in the same cycle as CSRRW `mscratch`-style write to `mepc` → `mepc` = `pc`, and the CSR write is dropped.
- `rst_n` low mid-operation → all outputs 0 asynchronously. With `CSR_MCYCLE_EN` defined, a read of 0xB00 five cycles after reset release returns 5.
